// File: rtl/servo_pkg.sv
// Shared codes and frame length for the servo position sequencer and the PWM generator.
package servo_pkg;

   // Default frame length: 20 ms at 50 MHz
   localparam int DEFAULT_FRAME_CYCLES = 1_000_000;

   // Command mode encodings
   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_ONCE = 2'b01;
   localparam logic [1:0] MODE_LOOP = 2'b10;
   localparam logic [1:0] MODE_RSVD = 2'b11;

   // Position codes understood by the PWM stage
   localparam logic [1:0] POS_0   = 2'b00;
   localparam logic [1:0] POS_90  = 2'b01;
   localparam logic [1:0] POS_180 = 2'b10;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ALIGN = 2'b01,
      ST_DWELL = 2'b10
   } seq_state_t;

endpackage

// File: rtl/servo_seq_frame_timer.sv
// Free-running frame counter: counts 0..FRAME_CYCLES-1 and flags the last cycle of each frame.
module frame_timer #(
   parameter int FRAME_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic frame_tick
);

   localparam int CW = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_CYCLES - 1);
   localparam logic [CW-1:0] PRE_LAST_CNT = CW'(FRAME_CYCLES - 2);

   logic [CW-1:0] count_r;
   logic          tick_r;

   // Wrap counter; the tick is registered one cycle ahead so it lines up with count == last
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {CW{1'b0}};
         tick_r  <= 1'b0;
      end else begin
         if (count_r == LAST_CNT) begin
            count_r <= {CW{1'b0}};
         end else begin
            count_r <= count_r + CW'(1);
         end
         tick_r <= (count_r == PRE_LAST_CNT);
      end
   end

   assign frame_tick = tick_r;

endmodule

// File: rtl/servo_seq.sv
// Servo position sequencer: turns HOLD / sweep commands into frame-aligned position codes.
module servo_seq
   import servo_pkg::*;
#(
   parameter int FRAME_CYCLES = DEFAULT_FRAME_CYCLES,
   parameter int DWELL_W      = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_mode,
   input  logic [1:0]         cmd_pos,
   input  logic [DWELL_W-1:0] cmd_dwell,
   input  logic               abort,
   output logic [1:0]         pos,
   output logic               busy,
   output logic               done,
   output logic               frame_tick
);

   // Position for a given step of the active command's table
   function automatic logic [1:0] step_pos(input logic [1:0] mode,
                                           input logic [1:0] hold_pos,
                                           input logic [2:0] step);
      logic [1:0] p;
      p = POS_0;
      case (mode)
         MODE_HOLD: p = hold_pos;
         MODE_ONCE, MODE_LOOP: begin
            case (step)
               3'd0:    p = POS_0;
               3'd1:    p = POS_90;
               3'd2:    p = POS_180;
               3'd3:    p = POS_90;
               3'd4:    p = POS_0;
               default: p = POS_0;
            endcase
         end
         default: p = POS_0;
      endcase
      return p;
   endfunction

   // True when the step is the final one of a terminating command
   function automatic logic is_last_step(input logic [1:0] mode, input logic [2:0] step);
      logic last;
      last = 1'b0;
      case (mode)
         MODE_HOLD: last = (step == 3'd0);
         MODE_ONCE: last = (step == 3'd4);
         default:   last = 1'b0;
      endcase
      return last;
   endfunction

   seq_state_t         state_r;
   logic [1:0]         mode_r;
   logic [1:0]         hold_pos_r;
   logic [DWELL_W-1:0] dwell_r;
   logic [DWELL_W-1:0] dwell_cnt_r;
   logic [2:0]         step_r;
   logic [1:0]         pos_r;
   logic               busy_r;
   logic               ready_r;
   logic               done_r;
   logic               tick_s;
   logic [2:0]         next_step_s;
   logic [DWELL_W-1:0] cmd_dwell_s;

   frame_timer #(
      .FRAME_CYCLES(FRAME_CYCLES)
   ) u_frame_timer (
      .clk       (clk),
      .rst       (rst),
      .frame_tick(tick_s)
   );

   // Next step index (the looping sweep wraps after its fourth step) and dwell of 0 read as 1
   always_comb begin
      next_step_s = step_r + 3'd1;
      if ((mode_r == MODE_LOOP) && (step_r == 3'd3)) begin
         next_step_s = 3'd0;
      end else begin
         next_step_s = step_r + 3'd1;
      end
      if (cmd_dwell == {DWELL_W{1'b0}}) begin
         cmd_dwell_s = DWELL_W'(1);
      end else begin
         cmd_dwell_s = cmd_dwell;
      end
   end

   // Sequencer FSM: accept, frame-aligned stepping, abort and completion pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         mode_r      <= MODE_HOLD;
         hold_pos_r  <= POS_0;
         dwell_r     <= DWELL_W'(1);
         dwell_cnt_r <= DWELL_W'(1);
         step_r      <= 3'd0;
         pos_r       <= POS_0;
         busy_r      <= 1'b0;
         ready_r     <= 1'b1;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (cmd_valid) begin
                  if (cmd_mode == MODE_RSVD) begin
                     // Reserved mode completes immediately without touching the output
                     done_r <= 1'b1;
                  end else begin
                     mode_r     <= cmd_mode;
                     hold_pos_r <= cmd_pos;
                     dwell_r    <= cmd_dwell_s;
                     step_r     <= 3'd0;
                     state_r    <= ST_ALIGN;
                     busy_r     <= 1'b1;
                     ready_r    <= 1'b0;
                  end
               end
            end
            ST_ALIGN: begin
               if (abort) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
               end else if (tick_s) begin
                  pos_r       <= step_pos(mode_r, hold_pos_r, 3'd0);
                  dwell_cnt_r <= dwell_r;
                  state_r     <= ST_DWELL;
               end
            end
            ST_DWELL: begin
               if (abort) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
               end else if (tick_s) begin
                  if (dwell_cnt_r > DWELL_W'(1)) begin
                     dwell_cnt_r <= dwell_cnt_r - DWELL_W'(1);
                  end else if (is_last_step(mode_r, step_r)) begin
                     done_r  <= 1'b1;
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                     ready_r <= 1'b1;
                  end else begin
                     step_r      <= next_step_s;
                     pos_r       <= step_pos(mode_r, hold_pos_r, next_step_s);
                     dwell_cnt_r <= dwell_r;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready  = ready_r;
   assign pos        = pos_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign frame_tick = tick_s;

endmodule

// File: tb/tb_servo_seq.sv
// Directed self-checking bench for servo_seq with a 100-cycle frame.
module tb_servo_seq;

   localparam int FC = 100;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_mode;
   logic [1:0]    cmd_pos;
   logic [DW-1:0] cmd_dwell;
   logic          abort;
   logic [1:0]    pos;
   logic          busy;
   logic          done;
   logic          frame_tick;

   int checks = 0;
   int failures = 0;
   int fc_m = 0;

   logic [1:0] once_tbl [5] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
   logic [1:0] loop_tbl [4] = '{2'b00, 2'b01, 2'b10, 2'b01};

   servo_seq #(.FRAME_CYCLES(FC), .DWELL_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_mode  (cmd_mode),
      .cmd_pos   (cmd_pos),
      .cmd_dwell (cmd_dwell),
      .abort     (abort),
      .pos       (pos),
      .busy      (busy),
      .done      (done),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   // One clock; the bench tracks where in the frame it is, then samples 1 time unit later
   task automatic cycle();
      @(posedge clk);
      if (rst) fc_m = 0;
      else fc_m = (fc_m == FC - 1) ? 0 : fc_m + 1;
      #1;
   endtask

   task automatic advance_to(input int target);
      for (int i = 0; i < 2 * FC; i++) begin
         if (fc_m == target) break;
         cycle();
      end
   endtask

   task automatic issue(input logic [1:0] m, input logic [1:0] p, input logic [DW-1:0] d);
      cmd_valid = 1'b1; cmd_mode = m; cmd_pos = p; cmd_dwell = d;
      cycle();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
      end
      rst = 1'b0;
      checks++; if (pos !== 2'b00) begin failures++; $display("FAIL reset_pos got=%b exp=00", pos); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
      for (int k = 0; k < FC; k++) begin
         checks++;
         if (frame_tick !== (k == FC - 1)) begin failures++; $display("FAIL first_tick k=%0d got=%b exp=%b", k, frame_tick, (k == FC - 1)); end
         if (k < FC - 1) cycle();
      end
   endtask

   task automatic test_hold();
      advance_to(37);
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL hold_ready got=%b exp=1", cmd_ready); end
      issue(2'b00, 2'b10, 8'd2);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy got=%b exp=1", busy); end
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL hold_ready_busy got=%b exp=0", cmd_ready); end
      advance_to(FC - 1);
      checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL hold_tick got=%b exp=1", frame_tick); end
      checks++; if (pos !== 2'b00) begin failures++; $display("FAIL hold_pos_early got=%b exp=00", pos); end
      cycle();
      checks++; if (pos !== 2'b10) begin failures++; $display("FAIL hold_pos got=%b exp=10", pos); end
      advance_to(FC - 1); cycle();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL hold_done_early got=%b exp=0", done); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy2 got=%b exp=1", busy); end
      advance_to(FC - 1); cycle();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL hold_done got=%b exp=1", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hold_busy_end got=%b exp=0", busy); end
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL hold_ready_end got=%b exp=1", cmd_ready); end
      cycle();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL hold_done_width got=%b exp=0", done); end
      checks++; if (pos !== 2'b10) begin failures++; $display("FAIL hold_pos_after got=%b exp=10", pos); end
   endtask

   task automatic test_sweep_once();
      int done_cnt;
      done_cnt = 0;
      issue(2'b01, 2'b00, 8'd1);
      advance_to(FC - 1);
      checks++; if (pos !== 2'b10) begin failures++; $display("FAIL once_pos_pre got=%b exp=10", pos); end
      cycle();
      for (int s = 0; s < 5; s++) begin
         for (int k = 0; k < FC; k++) begin
            checks++; if (pos !== once_tbl[s]) begin failures++; $display("FAIL once_pos s=%0d k=%0d got=%b exp=%b", s, k, pos, once_tbl[s]); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL once_busy s=%0d k=%0d got=%b exp=1", s, k, busy); end
            if (done === 1'b1) done_cnt++;
            if (s == 2 && k == 50) begin
               checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL once_ready_mid got=%b exp=0", cmd_ready); end
               cmd_valid = 1'b1; cmd_mode = 2'b00; cmd_pos = 2'b00; cmd_dwell = 8'd1;
            end
            cycle();
            cmd_valid = 1'b0;
         end
      end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL once_done got=%b exp=1", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL once_busy_end got=%b exp=0", busy); end
      checks++; if (pos !== 2'b00) begin failures++; $display("FAIL once_pos_end got=%b exp=00", pos); end
      for (int i = 0; i < 5; i++) begin
         if (done === 1'b1) done_cnt++;
         cycle();
      end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL once_done_count got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_sweep_loop();
      issue(2'b10, 2'b00, 8'd0);
      advance_to(FC - 1); cycle();
      for (int f = 0; f < 10; f++) begin
         checks++; if (pos !== loop_tbl[f % 4]) begin failures++; $display("FAIL loop_pos f=%0d got=%b exp=%b", f, pos, loop_tbl[f % 4]); end
         for (int k = 0; k < FC; k++) begin
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL loop_done f=%0d got=%b exp=0", f, done); end
            cycle();
         end
      end
      checks++; if (pos !== 2'b10) begin failures++; $display("FAIL loop_pos10 got=%b exp=10", pos); end
      for (int i = 0; i < 20; i++) cycle();
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL loop_abort_busy got=%b exp=0", busy); end
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL loop_abort_ready got=%b exp=1", cmd_ready); end
      for (int i = 0; i < 150; i++) begin
         checks++; if (pos !== 2'b10) begin failures++; $display("FAIL loop_frozen i=%0d got=%b exp=10", i, pos); end
         checks++; if (done !== 1'b0) begin failures++; $display("FAIL loop_abort_done i=%0d got=%b exp=0", i, done); end
         cycle();
      end
   endtask

   task automatic test_reserved();
      issue(2'b11, 2'b01, 8'd1);
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL rsvd_done got=%b exp=1", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rsvd_busy got=%b exp=0", busy); end
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rsvd_ready got=%b exp=1", cmd_ready); end
      cycle();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rsvd_done_width got=%b exp=0", done); end
      for (int i = 0; i < 150; i++) begin
         checks++; if (busy !== 1'b0 || pos !== 2'b10) begin failures++; $display("FAIL rsvd_idle i=%0d busy=%b pos=%b exp busy=0 pos=10", i, busy, pos); end
         cycle();
      end
   endtask

   task automatic test_collisions();
      // abort on the same cycle as frame_tick
      issue(2'b01, 2'b00, 8'd1);
      advance_to(FC - 1); cycle();
      checks++; if (pos !== 2'b00) begin failures++; $display("FAIL col_pos_step0 got=%b exp=00", pos); end
      advance_to(FC - 1);
      abort = 1'b1;
      checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL col_tick got=%b exp=1", frame_tick); end
      cycle();
      abort = 1'b0;
      checks++; if (pos !== 2'b00) begin failures++; $display("FAIL col_abort_pos got=%b exp=00", pos); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL col_abort_busy got=%b exp=0", busy); end
      for (int i = 0; i < 120; i++) begin
         checks++; if (pos !== 2'b00 || done !== 1'b0) begin failures++; $display("FAIL col_after_abort i=%0d pos=%b done=%b exp pos=00 done=0", i, pos, done); end
         cycle();
      end
      // abort together with cmd_valid in IDLE: command still accepted
      abort = 1'b1;
      issue(2'b00, 2'b01, 8'd1);
      abort = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL col_idle_abort_busy got=%b exp=1", busy); end
      advance_to(FC - 1); cycle();
      checks++; if (pos !== 2'b01) begin failures++; $display("FAIL col_idle_abort_pos got=%b exp=01", pos); end
      advance_to(FC - 1); cycle();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL col_idle_abort_done got=%b exp=1", done); end
      // reset in the middle of a sweep
      issue(2'b01, 2'b00, 8'd1);
      advance_to(FC - 1); cycle();
      advance_to(FC - 1); cycle();
      checks++; if (pos !== 2'b01) begin failures++; $display("FAIL col_rst_pre_pos got=%b exp=01", pos); end
      for (int i = 0; i < 30; i++) cycle();
      rst = 1'b1;
      cycle();
      checks++; if (pos !== 2'b00) begin failures++; $display("FAIL col_rst_pos got=%b exp=00", pos); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL col_rst_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL col_rst_done got=%b exp=0", done); end
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL col_rst_ready got=%b exp=1", cmd_ready); end
      checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL col_rst_tick got=%b exp=0", frame_tick); end
      cycle();
      rst = 1'b0;
      advance_to(FC - 2);
      checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL col_rst_tick_early got=%b exp=0", frame_tick); end
      cycle();
      checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL col_rst_tick_realign got=%b exp=1", frame_tick); end
      checks++; if (busy !== 1'b0 || pos !== 2'b00) begin failures++; $display("FAIL col_rst_idle busy=%b pos=%b exp busy=0 pos=00", busy, pos); end
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_pos = 2'b00;
      cmd_dwell = 8'd0; abort = 1'b0;
      test_reset();
      test_hold();
      test_sweep_once();
      test_sweep_loop();
      test_reserved();
      test_collisions();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
